// File: rtl/data_mem_loader.sv
// Streams little-endian bytes into 32-bit words and writes them to the CPU data memory through its external port.
// One write cycle follows the 4th accepted byte; in_ready is low outside COLLECT, so the source holds bytes until then.
module data_mem_loader #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter logic [31:0] ADDR_STEP   = 32'd4,
  parameter int          COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [COUNT_WIDTH-1:0] num_words,
  input  logic                   in_valid,
  input  logic [7:0]             in_byte,
  output logic                   in_ready,
  output logic                   Ext_Mem_write,
  output logic [31:0]            Ext_wrdata_add,
  output logic [31:0]            Ext_wrdata,
  output logic                   cpu_hold,
  output logic                   busy,
  output logic                   done,
  output logic [COUNT_WIDTH-1:0] words_written
);

  typedef enum logic [1:0] {IDLE, COLLECT, WRITE, FINISH} state_t;

  state_t                 state, state_nxt;
  logic [1:0]             byte_idx;
  logic [23:0]            byte_buf;
  logic [31:0]            addr;
  logic [COUNT_WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (num_words == '0) ? FINISH : COLLECT;
      COLLECT: if (in_valid && byte_idx == 2'd3) state_nxt = WRITE;
      WRITE:   state_nxt = ((words_written + COUNT_WIDTH'(1)) < count) ? COLLECT : FINISH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // All outputs decode from registered state; no input reaches an output combinationally.
  assign in_ready      = (state == COLLECT);
  assign Ext_Mem_write = (state == WRITE);
  assign busy          = (state != IDLE);
  assign cpu_hold      = busy;
  assign done          = (state == FINISH);

  always_ff @(posedge clk) begin
    if (!reset) begin
      byte_idx       <= '0;
      byte_buf       <= '0;
      addr           <= '0;
      count          <= '0;
      words_written  <= '0;
      Ext_wrdata_add <= '0;
      Ext_wrdata     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            count         <= num_words;
            addr          <= BASE_ADDR;
            words_written <= '0;
            byte_idx      <= '0;
          end
        end
        COLLECT: begin
          if (in_valid) begin
            case (byte_idx)
              2'd0: byte_buf[7:0]   <= in_byte;
              2'd1: byte_buf[15:8]  <= in_byte;
              2'd2: byte_buf[23:16] <= in_byte;
              default: begin
                // Write port registers only change here, so they hold between writes.
                Ext_wrdata     <= {in_byte, byte_buf};
                Ext_wrdata_add <= addr;
              end
            endcase
            byte_idx <= byte_idx + 2'd1;
          end
        end
        WRITE: begin
          words_written <= words_written + COUNT_WIDTH'(1);
          addr          <= addr + ADDR_STEP;
        end
        default: ;
      endcase
    end
  end

endmodule
